// File: rtl/pkt_defs.sv
// Shared symbol, stream-type and state definitions for the
// packet-identifier byte link (framer and check_byte).
package pkt_defs;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] PAD = 8'hF7;

    localparam logic [1:0] tlp            = 2'b01;
    localparam logic [1:0] dllp           = 2'b10;
    localparam logic [1:0] not_valid_data = 2'b00;

    localparam int         CNT_W   = 11;
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        CB_NONE = 2'b00,
        CB_TLP  = 2'b01,
        CB_DLLP = 2'b10,
        CB_ERR  = 2'b11
    } cb_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        TAIL = 2'b10
    } fr_state_e;

    function automatic logic is_valid_type(input logic [1:0] t);
        return (t == tlp) || (t == dllp);
    endfunction

endpackage

// File: rtl/packet_framer.sv
// Transmit framer: wraps TLP/DLLP payload bytes in STP/SDP ... END/EDB
// and fills idle cycles with PAD or invalid symbols.
module packet_framer
    import pkt_defs::*;
#(
    parameter int DLLP_LEN = 6,
    parameter bit PAD_IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [1:0] pkt_type,
    input  logic [7:0] pkt_data,
    input  logic       pkt_last,
    input  logic       pkt_abort,
    output logic [7:0] data_out,
    output logic       DK,
    output logic       valid,
    output logic       len_err,
    output logic       type_err
);

    localparam logic [CNT_W-1:0] DLLP_LEN_C = CNT_W'(DLLP_LEN);
    localparam logic [7:0]       IDLE_DATA  = PAD_IDLE ? PAD : 8'h00;

    fr_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             is_dllp_q, is_dllp_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             dk_q, dk_d;
    logic             valid_q, valid_d;
    logic             len_err_q, len_err_d;
    logic             type_err_q, type_err_d;
    logic             len_mis;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        abort_d    = abort_q;
        is_dllp_d  = is_dllp_q;
        data_out_d = IDLE_DATA;
        dk_d       = PAD_IDLE;
        valid_d    = PAD_IDLE;
        len_err_d  = 1'b0;
        type_err_d = 1'b0;
        pkt_ready  = 1'b0;
        len_mis    = is_dllp_q && (cnt_q != DLLP_LEN_C);

        unique case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    if (is_valid_type(pkt_type)) begin
                        // First payload byte stays on the bus for DATA.
                        is_dllp_d  = (pkt_type == dllp);
                        data_out_d = (pkt_type == dllp) ? SDP : STP;
                        dk_d       = 1'b1;
                        valid_d    = 1'b1;
                        state_d    = DATA;
                    end else begin
                        pkt_ready  = 1'b1;
                        type_err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                pkt_ready  = 1'b1;
                data_out_d = 8'h00;
                dk_d       = 1'b0;
                valid_d    = 1'b0;
                if (pkt_valid) begin
                    data_out_d = pkt_data;
                    valid_d    = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (pkt_abort) begin
                        abort_d = 1'b1;
                    end
                    if (pkt_last) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                data_out_d = (abort_q || len_mis) ? EDB : END;
                dk_d       = 1'b1;
                valid_d    = 1'b1;
                len_err_d  = len_mis;
                cnt_d      = '0;
                abort_d    = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            is_dllp_q  <= 1'b0;
            data_out_q <= 8'h00;
            dk_q       <= 1'b0;
            valid_q    <= 1'b0;
            len_err_q  <= 1'b0;
            type_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            is_dllp_q  <= is_dllp_d;
            data_out_q <= data_out_d;
            dk_q       <= dk_d;
            valid_q    <= valid_d;
            len_err_q  <= len_err_d;
            type_err_q <= type_err_d;
        end
    end

    assign data_out = data_out_q;
    assign DK       = dk_q;
    assign valid    = valid_q;
    assign len_err  = len_err_q;
    assign type_err = type_err_q;

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer with a symbol-stream model
// and per-cycle output comparison.
module tb_packet_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pkt_valid = 1'b0;
    logic       pkt_ready;
    logic [1:0] pkt_type = 2'b00;
    logic [7:0] pkt_data = 8'h00;
    logic       pkt_last = 1'b0;
    logic       pkt_abort = 1'b0;
    logic [7:0] data_out;
    logic       DK;
    logic       valid;
    logic       len_err;
    logic       type_err;

    packet_framer #(.DLLP_LEN(6), .PAD_IDLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_type(pkt_type), .pkt_data(pkt_data),
        .pkt_last(pkt_last), .pkt_abort(pkt_abort),
        .data_out(data_out), .DK(DK), .valid(valid),
        .len_err(len_err), .type_err(type_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dk;
        logic [7:0] d;
        logic       le;
    } exp_t;

    typedef struct {
        logic       dk;
        logic [7:0] d;
        logic       le;
        int         cyc;
    } obs_t;

    exp_t       exp_q[$];
    obs_t       seen[$];
    logic [7:0] pl[$];

    int  pass_cnt = 0;
    int  total = 0;
    int  cyc = 0;
    int  bubbles = 0;
    int  te_seen = 0;
    int  te_exp = 0;
    bit  chk_en = 1'b0;
    bit  in_pkt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        $display("FAIL %s: got %0h, expected none", name, act);
    endtask

    // Compare process: every non-PAD valid symbol must be the next
    // symbol the model predicts; gaps inside a packet must be blank.
    always @(negedge clk) begin
        cyc++;
        if (chk_en && rst_n) begin
            if (type_err) te_seen++;
            if (valid && !(DK && data_out == 8'hF7)) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_sym", {23'd0, DK, data_out});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sym", {DK, data_out}, {e.dk, e.d});
                    chk("len_err", len_err, e.le);
                end
                seen.push_back('{DK, data_out, len_err, cyc});
                if (DK && (data_out == 8'hFB || data_out == 8'h5C))
                    in_pkt = 1'b1;
                if (DK && (data_out == 8'hFD || data_out == 8'hFE))
                    in_pkt = 1'b0;
            end else begin
                if (len_err) fail_now("len_err_stray", len_err);
                if (valid && in_pkt) fail_now("pad_in_pkt", data_out);
                if (!valid) begin
                    chk("blank", {DK, data_out}, 9'h000);
                    if (in_pkt) bubbles++;
                    else fail_now("idle_not_pad", valid);
                end
            end
        end
    end

    task automatic model_pkt(input logic [1:0] ty, input bit aborted);
        bit bad_len;
        bad_len = (ty == 2'b10) && (pl.size() != 6);
        exp_q.push_back('{1'b1, (ty == 2'b10) ? 8'h5C : 8'hFB, 1'b0});
        foreach (pl[i]) exp_q.push_back('{1'b0, pl[i], 1'b0});
        exp_q.push_back('{1'b1, (aborted || bad_len) ? 8'hFE : 8'hFD,
                         bad_len});
    endtask

    task automatic accept_beat();
        int b;
        b = 0;
        @(negedge clk);
        while (!pkt_ready && b < 20) begin
            b++;
            @(negedge clk);
        end
        if (!pkt_ready) fail_now("accept_timeout", b);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [1:0] ty, input int abort_idx,
                            input int stall_at, input int stall_len,
                            input bit hold);
        model_pkt(ty, abort_idx >= 0);
        for (int i = 0; i < pl.size(); i++) begin
            if (i == stall_at) begin
                pkt_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall_ready", pkt_ready, 1);
                    @(posedge clk);
                    #1;
                end
            end
            pkt_valid = 1'b1;
            pkt_type  = ty;
            pkt_data  = pl[i];
            pkt_last  = (i == pl.size() - 1);
            pkt_abort = (i == abort_idx);
            accept_beat();
        end
        if (!hold) begin
            pkt_valid = 1'b0;
            pkt_last  = 1'b0;
            pkt_abort = 1'b0;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 60) begin
            b++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) fail_now("drain_timeout", exp_q.size());
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int b0;
        logic [8:0] lit[$];

        #1;
        chk("rst_valid", valid, 0);
        chk("rst_dk", DK, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ready", pkt_ready, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_type_err", type_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // TLP 06..09: exact framed sequence, contiguous
        s0 = seen.size();
        pl = '{8'h06, 8'h07, 8'h08, 8'h09};
        send_pkt(2'b01, -1, -1, 0, 1'b0);
        drain();
        lit = '{9'h1FB, 9'h006, 9'h007, 9'h008, 9'h009, 9'h1FD};
        for (int k = 0; k < 6; k++) begin
            chk("tlp_lit", {seen[s0+k].dk, seen[s0+k].d}, lit[k]);
            chk("tlp_contig", seen[s0+k].cyc - seen[s0].cyc, k);
        end

        // DLLP of 6 bytes: END, no length error
        s0 = seen.size();
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(2'b10, -1, -1, 0, 1'b0);
        drain();
        chk("dllp6_start", {seen[s0].dk, seen[s0].d}, 9'h15C);
        chk("dllp6_term", {seen[s0+7].dk, seen[s0+7].d, seen[s0+7].le},
            10'h3FA);

        // DLLP of 5 bytes: EDB with len_err on the same cycle
        s0 = seen.size();
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_pkt(2'b10, -1, -1, 0, 1'b0);
        drain();
        chk("dllp5_term", {seen[s0+6].dk, seen[s0+6].d, seen[s0+6].le},
            10'h3FD);

        // Abort on 2nd byte, then a clean packet
        s0 = seen.size();
        pl = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'b01, 1, -1, 0, 1'b0);
        pl = '{8'h44};
        send_pkt(2'b01, -1, -1, 0, 1'b0);
        drain();
        chk("abort_term", {seen[s0+4].dk, seen[s0+4].d}, 9'h1FE);
        chk("after_abort", {seen[s0+7].dk, seen[s0+7].d}, 9'h1FD);

        // Back to back with pkt_valid held high
        repeat (3) @(posedge clk);
        #1;
        s0 = seen.size();
        pl = '{8'hAA, 8'hBB};
        send_pkt(2'b01, -1, -1, 0, 1'b1);
        pl = '{8'hCC};
        send_pkt(2'b01, -1, -1, 0, 1'b0);
        drain();
        lit = '{9'h1FB, 9'h0AA, 9'h0BB, 9'h1FD, 9'h1FB, 9'h0CC, 9'h1FD};
        for (int k = 0; k < 7; k++) begin
            chk("b2b_lit", {seen[s0+k].dk, seen[s0+k].d}, lit[k]);
            chk("b2b_contig", seen[s0+k].cyc - seen[s0].cyc, k);
        end

        // Idle source with PAD_IDLE=1
        @(negedge clk);
        chk("pad_idle", {valid, DK, data_out}, 10'h3F7);
        @(posedge clk);
        #1;

        // Stall of 3 cycles before the 3rd byte
        b0 = bubbles;
        pl = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        send_pkt(2'b01, -1, 2, 3, 1'b0);
        drain();
        chk("stall_bubbles", bubbles - b0, 3);

        // Invalid type 11 in IDLE is consumed and flagged
        pkt_valid = 1'b1;
        pkt_type  = 2'b11;
        pkt_data  = 8'h99;
        pkt_last  = 1'b1;
        @(negedge clk);
        chk("type_ready", pkt_ready, 1);
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        te_exp++;
        @(negedge clk);
        chk("type_err_pulse", type_err, 1);
        chk("type_err_idle", {valid, DK, data_out}, 10'h3F7);
        @(negedge clk);
        chk("type_err_once", type_err, 0);
        @(posedge clk);
        #1;

        // Reset mid-DATA
        chk_en    = 1'b0;
        pkt_valid = 1'b1;
        pkt_type  = 2'b01;
        pkt_data  = 8'h55;
        pkt_last  = 1'b0;
        accept_beat();
        accept_beat();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_dk", DK, 0);
        chk("mid_rst_ready", pkt_ready, 0);
        pkt_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_pkt = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {valid, DK, data_out, pkt_ready}, 11'h7EE);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        s0 = seen.size();
        pl = '{8'h77};
        send_pkt(2'b01, -1, -1, 0, 1'b0);
        drain();
        lit = '{9'h1FB, 9'h077, 9'h1FD};
        for (int k = 0; k < 3; k++)
            chk("post_rst_pkt", {seen[s0+k].dk, seen[s0+k].d}, lit[k]);

        chk("type_err_count", te_seen, te_exp);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
